// File: rtl/mapper_trap_ctrl.sv
// Mapper page translation, guest I/O trap FIFO, timed NMI and hypervisor exit sequencing.
module mapper_trap_ctrl #(
   parameter int unsigned PAGE_BITS  = 2,
   parameter int unsigned PHYS_W     = 8,
   parameter int unsigned TRAP_DEPTH = 4,
   parameter int unsigned NMI_CYCLES = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [15:0]       bus_addr,
   input  logic [7:0]        bus_wdata,
   input  logic              io_strobe,
   input  logic              io_write,
   input  logic              io_mapper,
   input  logic              m1_strobe,
   input  logic              irq_sys_n,
   output logic [7:0]        bus_rdata,
   output logic              trans_en,
   output logic [PHYS_W-1:0] trans_page,
   output logic              trapped,
   output logic              nmi_n,
   output logic              irq_n
);

   localparam int unsigned PAGES = 1 << PAGE_BITS;
   localparam int unsigned PTR_W = $clog2(TRAP_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned NMI_W = $clog2(NMI_CYCLES) + 1;
   localparam int unsigned ENT_W = 17;

   typedef enum logic [2:0] {S_RUN, S_NMI, S_TRAPPED, S_EXIT_ARM, S_EXIT_JMP} state_t;

   state_t              state, state_nxt;
   logic [1:0]          ctrl, ctrl_nxt;
   logic                nmi_n_nxt, trapped_nxt, trans_en_nxt;
   logic                overflow;
   logic [ENT_W-1:0]    fifo_mem [TRAP_DEPTH];
   logic [PTR_W-1:0]    rd_ptr, wr_ptr;
   logic [CNT_W-1:0]    fifo_cnt;
   logic [7:0]          viol_cnt;
   logic [PHYS_W-1:0]   page_tbl [PAGES];
   logic [PAGE_BITS-1:0] tbl_index;
   logic [NMI_W-1:0]    nmi_cnt;
   logic [7:0]          rd_mux;

   logic                reg_wr, reg_rd, in_guest, in_trap, violation;
   logic                fifo_empty, fifo_full, pop, push_ok, push_drop;
   logic [2:0]          reg_sel;
   logic [1:0]          cnt_field;
   logic [ENT_W-1:0]    head;

   // Bus decode and FIFO handshake terms
   always_comb begin
      reg_sel    = bus_addr[2:0];
      reg_wr     = io_strobe && io_mapper && io_write;
      reg_rd     = io_strobe && io_mapper && !io_write;
      in_guest   = (state == S_RUN) || (state == S_NMI);
      in_trap    = !in_guest;
      violation  = io_strobe && !io_mapper && ctrl[0] && in_guest;
      fifo_empty = (fifo_cnt == '0);
      fifo_full  = (fifo_cnt == CNT_W'(TRAP_DEPTH));
      pop        = reg_rd && (reg_sel == 3'd3) && !fifo_empty;
      push_ok    = violation && (!fifo_full || pop);
      push_drop  = violation && fifo_full && !pop;
      cnt_field  = (fifo_cnt > CNT_W'(3)) ? 2'd3 : fifo_cnt[1:0];
      head       = fifo_mem[rd_ptr];
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_RUN;
      else          state <= state_nxt;
   end

   // Next-state logic and next values of the registered status outputs
   always_comb begin
      state_nxt = state;
      ctrl_nxt  = ctrl;
      if (reg_wr && (reg_sel == 3'd0)) ctrl_nxt = bus_wdata[1:0];
      case (state)
         S_RUN:      if (violation) state_nxt = S_NMI;
         S_NMI:      if (nmi_cnt == NMI_W'(NMI_CYCLES - 1)) state_nxt = S_TRAPPED;
         S_TRAPPED:  if (reg_wr && (reg_sel == 3'd7)) state_nxt = S_EXIT_ARM;
         S_EXIT_ARM: if (m1_strobe && ((bus_wdata == 8'hC3) || (bus_wdata == 8'hE9)))
                        state_nxt = S_EXIT_JMP;
         S_EXIT_JMP: if (m1_strobe) state_nxt = S_RUN;
         default:    state_nxt = S_RUN;
      endcase
      nmi_n_nxt    = (state_nxt != S_NMI);
      trapped_nxt  = (state_nxt == S_TRAPPED) || (state_nxt == S_EXIT_ARM) ||
                     (state_nxt == S_EXIT_JMP);
      trans_en_nxt = ctrl_nxt[0] && ((state_nxt == S_RUN) || (state_nxt == S_NMI));
   end

   // Register read mux; empty FIFO peeks and pops read as zero
   always_comb begin
      rd_mux = 8'h00;
      case (reg_sel)
         3'd0: rd_mux = {overflow, in_trap, fifo_empty, fifo_full, 2'b00, cnt_field};
         3'd1: if (!fifo_empty) rd_mux = head[7:0];
         3'd2: if (!fifo_empty) rd_mux = head[15:8];
         3'd3: if (!fifo_empty) rd_mux = {head[16], 7'h00};
         3'd4: rd_mux = 8'(tbl_index);
         3'd5: rd_mux = 8'(page_tbl[tbl_index]);
         3'd6: rd_mux = viol_cnt;
         default: rd_mux = 8'h00;
      endcase
   end

   // Datapath: control, FIFO, counters, page table and registered outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ctrl      <= 2'b00;
         overflow  <= 1'b0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         fifo_cnt  <= '0;
         viol_cnt  <= 8'h00;
         tbl_index <= '0;
         nmi_cnt   <= '0;
         bus_rdata <= 8'h00;
         trans_en  <= 1'b0;
         trapped   <= 1'b0;
         nmi_n     <= 1'b1;
         irq_n     <= 1'b1;
         for (int i = 0; i < int'(TRAP_DEPTH); i++) fifo_mem[i] <= '0;
         for (int i = 0; i < int'(PAGES); i++) page_tbl[i] <= PHYS_W'(i);
      end else begin
         ctrl     <= ctrl_nxt;
         trans_en <= trans_en_nxt;
         trapped  <= trapped_nxt;
         nmi_n    <= nmi_n_nxt;
         irq_n    <= in_guest ? !ctrl[1] : irq_sys_n;

         if (state == S_NMI) nmi_cnt <= nmi_cnt + 1'b1;
         else                nmi_cnt <= '0;

         if (reg_rd) bus_rdata <= rd_mux;

         if (push_ok) begin
            fifo_mem[wr_ptr] <= {io_write, bus_addr};
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: ;
         endcase

         if (push_drop) overflow <= 1'b1;
         else if (reg_wr && (reg_sel == 3'd0) && bus_wdata[7]) overflow <= 1'b0;

         if (reg_wr && (reg_sel == 3'd6)) viol_cnt <= 8'h00;
         else if (violation && (viol_cnt != 8'hFF)) viol_cnt <= viol_cnt + 1'b1;

         if (reg_wr && (reg_sel == 3'd4)) tbl_index <= bus_wdata[PAGE_BITS-1:0];
         if (reg_wr && (reg_sel == 3'd5)) begin
            page_tbl[tbl_index] <= bus_wdata[PHYS_W-1:0];
            tbl_index           <= tbl_index + 1'b1;
         end
      end
   end

   // Combinational page lookup from the upper address bits
   assign trans_page = page_tbl[bus_addr[15 -: PAGE_BITS]];

endmodule

// File: tb/tb_mapper_trap_ctrl.sv
// Scoreboard bench for mapper_trap_ctrl: stimulus queues expectations, a monitor compares.
module tb_mapper_trap_ctrl;

   localparam int ID_NMI   = 0;
   localparam int ID_TRAP  = 1;
   localparam int ID_IRQ   = 2;
   localparam int ID_TEN   = 3;
   localparam int ID_PAGE  = 4;
   localparam int ID_RDATA = 5;

   typedef struct {
      string       name;
      int          id;
      logic [15:0] exp;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] bus_addr;
   logic [7:0]  bus_wdata;
   logic        io_strobe, io_write, io_mapper, m1_strobe, irq_sys_n;
   logic [7:0]  bus_rdata;
   logic        trans_en, trapped, nmi_n, irq_n;
   logic [7:0]  trans_page;

   exp_t rd_q[$];
   exp_t sig_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   logic rd_fire = 1'b0;
   logic end_req = 1'b0;
   logic end_done = 1'b0;

   mapper_trap_ctrl #(.PAGE_BITS(2), .PHYS_W(8), .TRAP_DEPTH(4), .NMI_CYCLES(4)) dut (
      .clk(clk), .reset_n(reset_n), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .io_strobe(io_strobe), .io_write(io_write), .io_mapper(io_mapper),
      .m1_strobe(m1_strobe), .irq_sys_n(irq_sys_n), .bus_rdata(bus_rdata),
      .trans_en(trans_en), .trans_page(trans_page), .trapped(trapped),
      .nmi_n(nmi_n), .irq_n(irq_n)
   );

   always #5 clk = ~clk;

   // Remember which cycles carried a register read so the monitor knows when data is due
   always @(posedge clk) rd_fire <= io_strobe && io_mapper && !io_write;

   function automatic logic [15:0] sig_val(input int id);
      case (id)
         ID_NMI:   return 16'(nmi_n);
         ID_TRAP:  return 16'(trapped);
         ID_IRQ:   return 16'(irq_n);
         ID_TEN:   return 16'(trans_en);
         ID_PAGE:  return 16'(trans_page);
         default:  return 16'(bus_rdata);
      endcase
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compares read data when due, and any queued signal checks each cycle
   always @(negedge clk) begin
      exp_t e;
      if (rd_fire) begin
         if (rd_q.size() == 0) begin
            check("rdata_unexpected", 16'(bus_rdata), 16'hFFFF);
         end else begin
            e = rd_q.pop_front();
            check(e.name, 16'(bus_rdata), e.exp);
         end
      end
      while (sig_q.size() != 0) begin
         e = sig_q.pop_front();
         check(e.name, sig_val(e.id), e.exp);
      end
      if (end_req && !end_done) begin
         check("queues_drained", 16'(rd_q.size() + sig_q.size()), 16'h0000);
         end_done = 1'b1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic io_cycle(input logic mapper, input logic wr, input logic [15:0] addr,
                           input logic [7:0] d);
      io_strobe = 1'b1; io_mapper = mapper; io_write = wr; bus_addr = addr; bus_wdata = d;
      step();
      io_strobe = 1'b0; io_mapper = 1'b0; io_write = 1'b0;
   endtask

   task automatic rd(input logic [2:0] r, input logic [7:0] exp, input string name);
      exp_t e;
      e.name = name; e.id = ID_RDATA; e.exp = 16'(exp);
      rd_q.push_back(e);
      io_cycle(1'b1, 1'b0, {13'h0, r}, 8'h00);
   endtask

   task automatic wr(input logic [2:0] r, input logic [7:0] d);
      io_cycle(1'b1, 1'b1, {13'h0, r}, d);
   endtask

   task automatic viol(input logic [15:0] addr, input logic w);
      io_cycle(1'b0, w, addr, 8'h00);
   endtask

   task automatic m1(input logic [7:0] op);
      m1_strobe = 1'b1; bus_wdata = op;
      step();
      m1_strobe = 1'b0;
   endtask

   task automatic chk(input string name, input int id, input logic [15:0] exp);
      exp_t e;
      e.name = name; e.id = id; e.exp = exp;
      sig_q.push_back(e);
   endtask

   // Called the cycle after the violating strobe: nmi_n low 4 clocks, then trapped
   task automatic nmi_seq(input string tag);
      chk({tag, "_nmi_low0"}, ID_NMI, 16'd0);
      chk({tag, "_trap_low"}, ID_TRAP, 16'd0);
      for (int k = 1; k < 4; k++) begin
         step();
         chk({tag, "_nmi_low"}, ID_NMI, 16'd0);
      end
      step();
      chk({tag, "_nmi_high"}, ID_NMI, 16'd1);
      chk({tag, "_trapped"}, ID_TRAP, 16'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0; bus_addr = 16'h0; bus_wdata = 8'h0; io_strobe = 1'b0;
      io_write = 1'b0; io_mapper = 1'b0; m1_strobe = 1'b0; irq_sys_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // Reset state and register readback
      chk("rst_nmi_n", ID_NMI, 16'd1);
      chk("rst_trapped", ID_TRAP, 16'd0);
      chk("rst_irq_n", ID_IRQ, 16'd1);
      chk("rst_trans_en", ID_TEN, 16'd0);
      chk("rst_trans_page", ID_PAGE, 16'd0);
      chk("rst_rdata", ID_RDATA, 16'd0);
      rd(3'd0, 8'h20, "rst_status");
      rd(3'd1, 8'h00, "rst_peek_lo");
      rd(3'd2, 8'h00, "rst_peek_hi");
      rd(3'd3, 8'h00, "rst_pop_empty");
      rd(3'd6, 8'h00, "rst_viol_cnt");
      rd(3'd7, 8'h00, "rst_reg7");
      rd(3'd4, 8'h00, "rst_index");
      rd(3'd5, 8'h00, "rst_tbl0");
      for (int i = 1; i < 4; i++) begin
         wr(3'd4, 8'(i));
         rd(3'd5, 8'(i), "rst_tbl_identity");
      end

      // Single trapped OUT
      wr(3'd0, 8'h01);
      chk("virt_trans_en", ID_TEN, 16'd1);
      viol(16'h40A1, 1'b1);
      nmi_seq("t1");
      chk("t1_trans_en_off", ID_TEN, 16'd0);
      rd(3'd6, 8'h01, "t1_viol_cnt");
      rd(3'd0, 8'h41, "t1_status");
      rd(3'd1, 8'hA1, "t1_peek_lo");
      rd(3'd2, 8'h40, "t1_peek_hi");
      rd(3'd3, 8'h80, "t1_pop_dir");
      rd(3'd0, 8'h60, "t1_status_empty");

      // Exit sequence: non-jump opcode keeps arming, JP arms the exit, next fetch leaves
      m1(8'hC3);
      chk("x_no_arm_trapped", ID_TRAP, 16'd1);
      wr(3'd7, 8'h00);
      m1(8'h3E);
      chk("x_arm_persist", ID_TRAP, 16'd1);
      m1(8'hC3);
      chk("x_jmp", ID_TRAP, 16'd1);
      m1(8'h00);
      chk("x_run", ID_TRAP, 16'd0);
      chk("x_trans_en", ID_TEN, 16'd1);

      // Five back-to-back violations overflow a four-entry FIFO
      wr(3'd6, 8'h00);
      viol(16'h1001, 1'b1);
      viol(16'h2002, 1'b0);
      viol(16'h3003, 1'b1);
      viol(16'h4004, 1'b0);
      viol(16'h5005, 1'b1);
      chk("ov_trapped", ID_TRAP, 16'd1);
      chk("ov_nmi_high", ID_NMI, 16'd1);
      rd(3'd0, 8'hD3, "ov_status");
      rd(3'd6, 8'h05, "ov_viol_cnt");
      rd(3'd1, 8'h01, "ov_peek0"); rd(3'd3, 8'h80, "ov_pop0");
      rd(3'd1, 8'h02, "ov_peek1"); rd(3'd3, 8'h00, "ov_pop1");
      rd(3'd2, 8'h30, "ov_peek2"); rd(3'd3, 8'h80, "ov_pop2");
      rd(3'd1, 8'h04, "ov_peek3"); rd(3'd3, 8'h00, "ov_pop3");
      rd(3'd0, 8'hE0, "ov_status_drained");
      wr(3'd0, 8'h81);
      rd(3'd0, 8'h60, "ov_cleared");

      // Exit via JP (HL)
      wr(3'd7, 8'h00);
      m1(8'hE9);
      chk("x2_jmp", ID_TRAP, 16'd1);
      m1(8'h12);
      chk("x2_run", ID_TRAP, 16'd0);

      // Page table writes with index auto-increment and wrap
      wr(3'd4, 8'h03);
      wr(3'd5, 8'h5A);
      wr(3'd5, 8'h11);
      rd(3'd4, 8'h01, "tbl_index_wrap");
      wr(3'd4, 8'h03);
      rd(3'd5, 8'h5A, "tbl3");
      wr(3'd4, 8'h00);
      rd(3'd5, 8'h11, "tbl0");
      bus_addr = 16'hC000;
      chk("page_c000", ID_PAGE, 16'h5A);
      chk("page_trans_en", ID_TEN, 16'd1);
      step();
      bus_addr = 16'h0123;
      chk("page_0123", ID_PAGE, 16'h11);
      step();
      bus_addr = 16'h8000;
      chk("page_8000", ID_PAGE, 16'h02);
      step();

      // Interrupt virtualisation
      wr(3'd0, 8'h03);
      step();
      chk("irq_forced", ID_IRQ, 16'd0);
      irq_sys_n = 1'b0;
      step();
      chk("irq_forced_sys_low", ID_IRQ, 16'd0);
      irq_sys_n = 1'b1;
      viol(16'h0055, 1'b0);
      chk("irq_forced_nmi", ID_IRQ, 16'd0);
      nmi_seq("t6");
      step();
      chk("irq_trap_sys_high", ID_IRQ, 16'd1);
      irq_sys_n = 1'b0;
      chk("irq_trap_lag", ID_IRQ, 16'd1);
      step();
      chk("irq_trap_follow_low", ID_IRQ, 16'd0);
      irq_sys_n = 1'b1;
      step();
      chk("irq_trap_follow_high", ID_IRQ, 16'd1);

      // Reset while trapped restores everything
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      bus_addr = 16'h0000;
      chk("mrst_trapped", ID_TRAP, 16'd0);
      chk("mrst_nmi_n", ID_NMI, 16'd1);
      chk("mrst_irq_n", ID_IRQ, 16'd1);
      chk("mrst_trans_en", ID_TEN, 16'd0);
      chk("mrst_rdata", ID_RDATA, 16'd0);
      chk("mrst_page0", ID_PAGE, 16'd0);
      rd(3'd0, 8'h20, "mrst_status");
      rd(3'd6, 8'h00, "mrst_viol_cnt");
      wr(3'd4, 8'h03);
      rd(3'd5, 8'h03, "mrst_tbl3");

      repeat (2) step();
      end_req = 1'b1;
      for (int k = 0; k < 20 && !end_done; k++) step();
      if (!end_done) begin
         $display("FAIL end_handshake: got no monitor response expected drain within 20 cycles");
         $fatal(1);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mapper_trap_ctrl.md
# mapper_trap_ctrl

Clocked, parametrised successor to the NABU mapper glue logic, placed between the Z80 bus sampler and the memory/I-O decode. It holds a page translation table of configurable depth and width. It traps guest I/O into a multi-entry capture FIFO, raises a timed NMI, and sequences the hypervisor exit through the jump-instruction handshake. Guest interrupts are virtualised while in guest mode.

## Interface
- PAGE_BITS, 2: upper address bits used as page index; table depth = 2^PAGE_BITS.
- PHYS_W, 8: width of translated page number (1..8).
- TRAP_DEPTH, 4: trap FIFO entries (power of 2, ≥2).
- NMI_CYCLES, 4: clocks nmi_n is held low (≥1).

- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- bus_addr  in  16  sampled Z80 address.
- bus_wdata  in  8  sampled Z80 data (writes, opcode fetch).
- io_strobe  in  1  one-clock pulse per Z80 I/O cycle.
- io_write  in  1  direction of that cycle (1 = OUT), valid with io_strobe.
- io_mapper  in  1  that cycle targets mapper register space; register select = bus_addr[2:0].
- m1_strobe  in  1  one-clock pulse per opcode fetch; opcode on bus_wdata.
- irq_sys_n  in  1  real system interrupt request.
- bus_rdata  out  8  register read data.
- trans_en  out  1  translation active.
- trans_page  out  PHYS_W  table[bus_addr[15 -: PAGE_BITS]].
- trapped  out  1  high in TRAPPED, EXIT_ARM, EXIT_JMP.
- nmi_n  out  1  NMI to CPU.
- irq_n  out  1  maskable interrupt to CPU.

## Operation
- States: RUN, NMI, TRAPPED, EXIT_ARM, EXIT_JMP. Reset → RUN.
- Control register: bit0 virt_en, bit1 force_irq. Reset value 0.
- Violation: io_strobe && !io_mapper && virt_en && state ∈ {RUN, NMI}.
  - Each violation pushes {io_write, bus_addr} into the FIFO.
  - Each violation increments an 8-bit saturating violation counter.
- Violation in RUN → NMI. A violation in NMI is captured but causes no transition.
- NMI: nmi_n low for exactly NMI_CYCLES clocks, then → TRAPPED.
- Register write 7 in TRAPPED → EXIT_ARM.
- EXIT_ARM: an m1_strobe with opcode 0xC3 or 0xE9 → EXIT_JMP. Other opcodes keep EXIT_ARM.
- EXIT_JMP: next m1_strobe → RUN.
- Register write 7 in any state other than TRAPPED is ignored.
- Mapper register accesses (io_strobe && io_mapper):
  - 0 R: {overflow, trapped, empty, full, 2'b0, count[1:0]}. count saturates at 3 in this field.
  - 0 W: control register = wdata[1:0]; wdata[7]=1 clears overflow.
  - 1 R: head addr[7:0] (peek).
  - 2 R: head addr[15:8] (peek).
  - 3 R: {dir, 7'b0}, then pops the FIFO.
  - 4 W: index = wdata[PAGE_BITS-1:0].
  - 4 R: index zero-extended.
  - 5 W: table[index] = wdata[PHYS_W-1:0], then index+1 (wraps).
  - 5 R: table[index] zero-extended.
  - 6 R: violation counter.
  - 6 W: clears violation counter.
  - 7 R: 0x00.
- FIFO rules:
  - Push when full: entry dropped, overflow sticky set.
  - Push and pop in the same cycle when full: both occur, count unchanged, no overflow.
  - Pop when empty: reads 0, no change.
  - Peeks when empty: return 0.
- Counter increment and a reg-6 clear in the same cycle: clear wins.
- Table reset: entry i = i mod 2^PHYS_W (identity). Index resets to 0.
- trans_en = virt_en && state ∈ {RUN, NMI}. trans_page is combinational from the table.
- irq_n: in RUN/NMI = !force_irq; otherwise = irq_sys_n.
- Reset mid-NMI or mid-trap: all state, FIFO, counter and table return to reset values on the next edge.

## Timing
- Reset outputs: bus_rdata=0, trans_en=0, trans_page=0, trapped=0, nmi_n=1, irq_n=1.
- Register writes take effect at the edge ending the strobe cycle and are visible the next clock.
- bus_rdata is registered: valid the clock after the read strobe and held until the next read.
- nmi_n goes low the clock after the violating io_strobe and is high again NMI_CYCLES clocks later.
- trapped rises the same edge that nmi_n returns high.
- irq_n is registered: 1-clock latency from force_irq, irq_sys_n or a state change.
- trans_page is 0-cycle from bus_addr and reflects a table write the clock after it.
- trapped falls the clock after the m1_strobe that exits EXIT_JMP.

## Test plan
- Reset, read all regs → status 0x20 (empty); table[i]=i; counter 0; nmi_n=1, irq_n=1.
- virt_en=1, OUT to 0x40A1 → nmi_n low 4 clocks, then trapped=1. Reads of regs 1/2/3 return 0xA1, 0x40, 0x80. Status then shows empty.
- Five violations with TRAP_DEPTH=4 → full=1, overflow=1, counter=5. Four pops return the first four addresses in order. Writing 0x81 to reg 0 clears overflow.
- In TRAPPED, write reg 7, fetch 0x3E then 0xC3 then 0x00 → EXIT_ARM persists after 0x3E, EXIT_JMP after 0xC3, RUN after the next fetch; trapped falls.
- Write index 3, data 0x5A, then 0x11 → table[3]=0x5A, table[0]=0x11 (wrap). With bus_addr=0xC000 and virt_en=1 → trans_page=0x5A, trans_en=1.
- force_irq=1 in RUN → irq_n=0 regardless of irq_sys_n. In TRAPPED, irq_n follows irq_sys_n with 1-clock lag.
